// File: rtl/hynoc_packet_gen.sv
// HyNoC packet generator: emits programmable header flits plus N payload flits (incrementing or LFSR) into one router ingress port.
// First flit is registered one cycle after start is accepted, then up to 1 flit/cycle; writes pause while the downstream FIFO level is within FIFO_MARGIN of full.
module hynoc_packet_gen #(
    parameter int PAYLOAD_WIDTH = 32,
    parameter int FLIT_WIDTH = PAYLOAD_WIDTH + 1,
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int MAX_HEADERS = 4,
    parameter int LEN_WIDTH = 16,
    parameter int GAP_WIDTH = 8,
    parameter int FIFO_MARGIN = 2,
    parameter logic [PAYLOAD_WIDTH-1:0] LFSR_POLY = 32'h8020_0003
) (
    input  logic                                   gen_clk,
    input  logic                                   gen_arst_n,
    input  logic                                   cfg_start,
    input  logic                                   cfg_stop,
    input  logic [$clog2(MAX_HEADERS+1)-1:0]       cfg_header_count,
    input  logic [MAX_HEADERS*PAYLOAD_WIDTH-1:0]   cfg_headers,
    input  logic [LEN_WIDTH-1:0]                   cfg_length,
    input  logic [LEN_WIDTH-1:0]                   cfg_packets,
    input  logic [GAP_WIDTH-1:0]                   cfg_gap,
    input  logic                                   cfg_mode,
    input  logic [PAYLOAD_WIDTH-1:0]               cfg_seed,
    output logic                                   egress_srst,
    output logic                                   egress_clk,
    output logic                                   egress_write,
    output logic [FLIT_WIDTH-1:0]                  egress_data,
    input  logic [LOG2_FIFO_DEPTH:0]               egress_fifo_level,
    output logic                                   busy,
    output logic                                   done,
    output logic [LEN_WIDTH-1:0]                   pkt_count,
    output logic [31:0]                            flit_count
);

    localparam int HC_W = $clog2(MAX_HEADERS + 1);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_END     = 3'd4;

    localparam logic [LOG2_FIFO_DEPTH:0] CREDIT_LIMIT =
        (LOG2_FIFO_DEPTH+1)'((1 << LOG2_FIFO_DEPTH) - FIFO_MARGIN);
    localparam logic [HC_W-1:0]          HC_ONE  = 1;
    localparam logic [HC_W-1:0]          HC_MAX  = HC_W'(MAX_HEADERS);
    localparam logic [LEN_WIDTH-1:0]     LEN_ONE = 1;
    localparam logic [GAP_WIDTH-1:0]     GAP_ONE = 1;
    localparam logic [PAYLOAD_WIDTH-1:0] PAY_ONE = 1;

    logic [2:0]                         state;
    logic                               srst_meta;
    logic [MAX_HEADERS*PAYLOAD_WIDTH-1:0] hdr_sh;
    logic [MAX_HEADERS*PAYLOAD_WIDTH-1:0] hdr_work;
    logic [HC_W-1:0]                    hdr_n_sh;
    logic [HC_W-1:0]                    hdr_idx;
    logic [LEN_WIDTH-1:0]               len_sh;
    logic [LEN_WIDTH-1:0]               pkts_sh;
    logic [LEN_WIDTH-1:0]               pay_idx;
    logic [GAP_WIDTH-1:0]               gap_sh;
    logic [GAP_WIDTH-1:0]               gap_cnt;
    logic                               mode_sh;
    logic [PAYLOAD_WIDTH-1:0]           dat;
    logic                               stop_pending;

    logic                               credit;
    logic                               pay_last;
    logic [LEN_WIDTH-1:0]               pkt_inc;
    logic                               run_over;
    logic [PAYLOAD_WIDTH-1:0]           dat_next;

    assign egress_clk = gen_clk;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_END);

    // Level is compared against the value seen before the write edge; the write itself is registered.
    assign credit   = (egress_fifo_level < CREDIT_LIMIT);
    assign pay_last = (pay_idx == len_sh - LEN_ONE) || stop_pending;
    assign pkt_inc  = (pkt_count == '1) ? pkt_count : pkt_count + LEN_ONE;
    assign run_over = stop_pending || ((pkts_sh != '0) && (pkt_inc == pkts_sh));
    assign dat_next = mode_sh ? ((dat >> 1) ^ (dat[0] ? LFSR_POLY : '0)) : dat + PAY_ONE;

    always_ff @(posedge gen_clk or negedge gen_arst_n) begin
        if (!gen_arst_n) begin
            srst_meta   <= 1'b1;
            egress_srst <= 1'b1;
        end else begin
            srst_meta   <= 1'b0;
            egress_srst <= srst_meta;
        end
    end

    always_ff @(posedge gen_clk or negedge gen_arst_n) begin
        if (!gen_arst_n) begin
            state        <= S_IDLE;
            hdr_sh       <= '0;
            hdr_work     <= '0;
            hdr_n_sh     <= HC_ONE;
            hdr_idx      <= '0;
            len_sh       <= LEN_ONE;
            pkts_sh      <= '0;
            pay_idx      <= '0;
            gap_sh       <= '0;
            gap_cnt      <= '0;
            mode_sh      <= 1'b0;
            dat          <= '0;
            stop_pending <= 1'b0;
            pkt_count    <= '0;
            flit_count   <= '0;
            egress_write <= 1'b0;
            egress_data  <= '0;
        end else begin
            egress_write <= 1'b0;
            egress_data  <= '0;
            if ((state != S_IDLE) && cfg_stop) begin
                stop_pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    // The synchronised downstream reset holds the engine idle.
                    if (cfg_start && !egress_srst) begin
                        hdr_sh       <= cfg_headers;
                        hdr_work     <= cfg_headers;
                        if (cfg_header_count == '0)        hdr_n_sh <= HC_ONE;
                        else if (cfg_header_count > HC_MAX) hdr_n_sh <= HC_MAX;
                        else                               hdr_n_sh <= cfg_header_count;
                        len_sh       <= (cfg_length == '0) ? LEN_ONE : cfg_length;
                        pkts_sh      <= cfg_packets;
                        gap_sh       <= cfg_gap;
                        mode_sh      <= cfg_mode;
                        dat          <= (cfg_mode && (cfg_seed == '0)) ? PAY_ONE : cfg_seed;
                        hdr_idx      <= '0;
                        stop_pending <= 1'b0;
                        pkt_count    <= '0;
                        flit_count   <= '0;
                        state        <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (credit) begin
                        egress_write <= 1'b1;
                        egress_data  <= {1'b0, hdr_work[PAYLOAD_WIDTH-1:0]};
                        hdr_work     <= hdr_work >> PAYLOAD_WIDTH;
                        flit_count   <= flit_count + 32'd1;
                        if (hdr_idx == hdr_n_sh - HC_ONE) begin
                            pay_idx <= '0;
                            state   <= S_PAYLOAD;
                        end else begin
                            hdr_idx <= hdr_idx + HC_ONE;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (credit) begin
                        egress_write <= 1'b1;
                        egress_data  <= {pay_last, dat};
                        dat          <= dat_next;
                        flit_count   <= flit_count + 32'd1;
                        if (pay_last) begin
                            pkt_count <= pkt_inc;
                            hdr_idx   <= '0;
                            hdr_work  <= hdr_sh;
                            if (run_over) begin
                                state <= S_END;
                            end else if (gap_sh != '0) begin
                                gap_cnt <= gap_sh - GAP_ONE;
                                state   <= S_GAP;
                            end else begin
                                state <= S_HEADER;
                            end
                        end else begin
                            pay_idx <= pay_idx + LEN_ONE;
                        end
                    end
                end
                S_GAP: begin
                    if (stop_pending) begin
                        state <= S_END;
                    end else if (gap_cnt == '0) begin
                        state <= S_HEADER;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hynoc_packet_gen.sv
// Randomised scoreboard bench for hynoc_packet_gen against a packet-level reference model.
module tb_hynoc_packet_gen;

    localparam int FW = 33;

    logic          gen_clk = 1'b0;
    logic          gen_arst_n = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic [2:0]    cfg_header_count = '0;
    logic [127:0]  cfg_headers = '0;
    logic [15:0]   cfg_length = '0;
    logic [15:0]   cfg_packets = '0;
    logic [7:0]    cfg_gap = '0;
    logic          cfg_mode = 1'b0;
    logic [31:0]   cfg_seed = '0;
    logic          egress_srst;
    logic          egress_clk;
    logic          egress_write;
    logic [FW-1:0] egress_data;
    logic [5:0]    egress_fifo_level = '0;
    logic          busy;
    logic          done;
    logic [15:0]   pkt_count;
    logic [31:0]   flit_count;

    hynoc_packet_gen dut (
        .gen_clk(gen_clk), .gen_arst_n(gen_arst_n),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_header_count(cfg_header_count), .cfg_headers(cfg_headers),
        .cfg_length(cfg_length), .cfg_packets(cfg_packets), .cfg_gap(cfg_gap),
        .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
        .egress_srst(egress_srst), .egress_clk(egress_clk),
        .egress_write(egress_write), .egress_data(egress_data),
        .egress_fifo_level(egress_fifo_level),
        .busy(busy), .done(done), .pkt_count(pkt_count), .flit_count(flit_count)
    );

    initial forever #5 gen_clk = ~gen_clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;
    bit            lvl_rand = 1'b0;
    logic [5:0]    lvl_edge = '0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] mon_exp;
    int            wr_cycles[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge gen_clk);
        cyc++;
        lvl_edge = egress_fifo_level;
    end

    // Monitor: pops the scoreboard whenever the DUT writes a flit.
    initial forever begin
        @(negedge gen_clk);
        if (gen_arst_n) begin
            chk("egress_clk_follows", {63'd0, egress_clk}, {63'd0, gen_clk});
            if (egress_write) begin
                wr_cycles.push_back(cyc);
                chk("credit_respected", {63'd0, lvl_edge < 6'd30}, 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got 0x%0h, expected no write (cycle %0d)", egress_data, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("flit", {31'd0, egress_data}, {31'd0, mon_exp});
                end
            end else begin
                chk("idle_data_zero", {31'd0, egress_data}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge gen_clk);
        #2;
        if (lvl_rand) egress_fifo_level = 6'($urandom_range(0, 32));
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference model: whole packets from the configuration, independent of timing.
    task automatic push_run(input int hc, input logic [127:0] hdrs, input int ln_cfg, input int pk,
                            input bit md, input logic [31:0] seed, input int stop_pay, output int nf);
        int hn;
        int ln;
        logic [31:0] d;
        bit last;
        hn = (hc == 0) ? 1 : hc;
        ln = (ln_cfg == 0) ? 1 : ln_cfg;
        d = (md && seed == 32'd0) ? 32'd1 : seed;
        nf = 0;
        for (int p = 0; p < pk; p++) begin
            for (int h = 0; h < hn; h++) begin
                exp_q.push_back({1'b0, hdrs[h*32 +: 32]});
                nf++;
            end
            for (int i = 0; i < ln; i++) begin
                last = (i == ln - 1) || (stop_pay != 0 && i == stop_pay - 1);
                exp_q.push_back({last, d});
                nf++;
                d = md ? lfsr_step(d) : d + 32'd1;
                if (last) break;
            end
        end
    endtask

    task automatic start_run(input int hc, input logic [127:0] hdrs, input int ln, input int pk,
                             input int gap, input bit md, input logic [31:0] seed,
                             input int stop_pay, input bit with_stop, output int nf);
        cfg_header_count = 3'(hc);
        cfg_headers      = hdrs;
        cfg_length       = 16'(ln);
        cfg_packets      = 16'(pk);
        cfg_gap          = 8'(gap);
        cfg_mode         = md;
        cfg_seed         = seed;
        push_run(hc, hdrs, ln, (pk == 0) ? 1 : pk, md, seed, stop_pay, nf);
        wr_cycles.delete();
        cfg_start = 1'b1;
        cfg_stop  = with_stop;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        start_cyc = cyc;
        // Scramble the configuration: the run must use its shadow copy.
        cfg_header_count = 3'($urandom_range(0, 4));
        cfg_headers      = {$urandom, $urandom, $urandom, $urandom};
        cfg_length       = 16'($urandom_range(1, 9));
        cfg_packets      = 16'($urandom_range(1, 9));
        cfg_gap          = 8'($urandom_range(0, 9));
        cfg_mode         = ~md;
        cfg_seed         = $urandom;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic finish_run(input int pk_exp, input int nf);
        chk("pkt_count", {48'd0, pkt_count}, 64'(pk_exp));
        chk("flit_count", {32'd0, flit_count}, 64'(nf));
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int nf;
        int nw;
        int rel;
        int hc, ln, pk, gap;
        bit md;
        logic [31:0] seed;

        #1 gen_arst_n = 1'b0;
        #1;
        chk("rst_write", {63'd0, egress_write}, 64'd0);
        chk("rst_data", {31'd0, egress_data}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        chk("rst_flit_count", {32'd0, flit_count}, 64'd0);
        chk("rst_srst", {63'd0, egress_srst}, 64'd1);
        repeat (3) tick();
        gen_arst_n = 1'b1;
        tick();
        chk("srst_edge1", {63'd0, egress_srst}, 64'd1);
        tick();
        chk("srst_edge2", {63'd0, egress_srst}, 64'd0);

        // Single header, single payload.
        start_run(1, {96'd0, 32'h0000_0AB2}, 1, 1, 0, 1'b0, 32'hCAFE_DECA, 0, 1'b0, nf);
        wait_done(50);
        finish_run(1, nf);
        chk("t1_writes", 64'(wr_cycles.size()), 64'd2);
        if (wr_cycles.size() == 2) begin
            chk("t1_first_latency", 64'(wr_cycles[0]), 64'(start_cyc + 1));
            chk("t1_consecutive", 64'(wr_cycles[1] - wr_cycles[0]), 64'd1);
            chk("t1_done_cycle", 64'(done_cyc), 64'(wr_cycles[1]));
        end

        // Two packets with a gap; start+stop together keeps the run; a start while busy is ignored.
        start_run(3, {$urandom, $urandom, $urandom, $urandom}, 3, 2, 4, 1'b0, 32'h0123_4567, 0, 1'b1, nf);
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_done(200);
        finish_run(2, nf);
        chk("t2_writes", 64'(wr_cycles.size()), 64'd12);
        if (wr_cycles.size() == 12) begin
            chk("t2_pkt0_burst", 64'(wr_cycles[5] - wr_cycles[0]), 64'd5);
            chk("t2_gap_4_idle", 64'(wr_cycles[6] - wr_cycles[5]), 64'd5);
            chk("t2_pkt1_burst", 64'(wr_cycles[11] - wr_cycles[6]), 64'd5);
        end

        // Credit threshold: 30 blocks, 29 passes.
        egress_fifo_level = 6'd30;
        start_run(2, {$urandom, $urandom, $urandom, $urandom}, 2, 1, 0, 1'b0, $urandom, 0, 1'b0, nf);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_no_write", {63'd0, egress_write}, 64'd0);
        end
        egress_fifo_level = 6'd29;
        rel = cyc;
        tick();
        chk("resume_write", {63'd0, egress_write}, 64'd1);
        wait_done(100);
        finish_run(1, nf);
        if (wr_cycles.size() > 0) chk("resume_cycle", 64'(wr_cycles[0]), 64'(rel + 1));
        egress_fifo_level = 6'd0;

        // LFSR with zero seed.
        start_run(1, {$urandom, $urandom, $urandom, $urandom}, 4, 1, 0, 1'b1, 32'd0, 0, 1'b0, nf);
        wait_done(50);
        finish_run(1, nf);

        // Continuous run stopped during payload 5.
        start_run(1, {$urandom, $urandom, $urandom, $urandom}, 100, 0, 2, 1'b0, $urandom, 6, 1'b0, nf);
        nw = 0;
        for (int i = 0; i < 50 && nw < 5; i++) begin
            tick();
            if (egress_write) nw++;
        end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_done(50);
        finish_run(1, nf);

        // Reset mid-payload, start ignored while srst is high, then a normal run.
        start_run(2, {$urandom, $urandom, $urandom, $urandom}, 50, 1, 0, 1'b0, $urandom, 0, 1'b0, nf);
        nw = 0;
        for (int i = 0; i < 50 && nw < 6; i++) begin
            tick();
            if (egress_write) nw++;
        end
        gen_arst_n = 1'b0;
        #1;
        chk("mid_rst_write", {63'd0, egress_write}, 64'd0);
        chk("mid_rst_srst", {63'd0, egress_srst}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_flit_count", {32'd0, flit_count}, 64'd0);
        exp_q.delete();
        tick();
        gen_arst_n = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("post_rst_srst_edge1", {63'd0, egress_srst}, 64'd1);
        chk("start_ignored_in_srst", {63'd0, busy}, 64'd0);
        tick();
        chk("post_rst_srst_edge2", {63'd0, egress_srst}, 64'd0);
        start_run(2, {$urandom, $urandom, $urandom, $urandom}, 3, 1, 0, 1'b0, $urandom, 0, 1'b0, nf);
        wait_done(50);
        finish_run(1, nf);

        // Randomised configurations under random backpressure.
        lvl_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            hc   = $urandom_range(0, 4);
            ln   = $urandom_range(0, 6);
            pk   = $urandom_range(1, 3);
            gap  = $urandom_range(0, 3);
            md   = 1'($urandom_range(0, 1));
            seed = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            start_run(hc, {$urandom, $urandom, $urandom, $urandom}, ln, pk, gap, md, seed, 0, 1'b0, nf);
            wait_done(3000);
            finish_run(pk, nf);
        end
        lvl_rand = 1'b0;
        egress_fifo_level = 6'd0;

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hynoc_packet_gen.md
# hynoc_packet_gen

Parametrised, synthesisable HyNoC packet generator that drives one router ingress port. It replaces hand-written per-cycle stimulus with a configurable engine. Per packet it emits a programmable header-flit sequence and N payload flits (incrementing or LFSR data), with the close bit on the last flit. Flow control comes from the downstream ingress FIFO level. It sits on any free router port, either in benches or as an on-chip built-in self-test (BIST) traffic source.

## Interface
- PAYLOAD_WIDTH, 32, payload bits per flit
- FLIT_WIDTH, PAYLOAD_WIDTH+1, flit width; MSB is the close bit
- LOG2_FIFO_DEPTH, 5, log2 of the downstream ingress FIFO depth
- MAX_HEADERS, 4, maximum header flits per packet (1..MAX_HEADERS)
- LEN_WIDTH, 16, width of the length and packet counters
- GAP_WIDTH, 8, width of the inter-packet gap counter
- FIFO_MARGIN, 2, free-slot margin that absorbs level-feedback latency
- LFSR_POLY, 32'h8020_0003, Galois feedback mask; width PAYLOAD_WIDTH

Ports:
- gen_clk  in  1  single clock for all logic
- gen_arst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; ignored unless idle
- cfg_stop  in  1  one-cycle graceful-stop pulse
- cfg_header_count  in  $clog2(MAX_HEADERS+1)  header flits per packet; 0 is treated as 1
- cfg_headers  in  MAX_HEADERS*PAYLOAD_WIDTH  header words; word 0 sits in the LSBs and is sent first
- cfg_length  in  LEN_WIDTH  payload flits per packet; 0 is treated as 1
- cfg_packets  in  LEN_WIDTH  packets to send; 0 means continuous until stopped
- cfg_gap  in  GAP_WIDTH  idle cycles between packets
- cfg_mode  in  1  0 selects incrementing data, 1 selects LFSR data
- cfg_seed  in  PAYLOAD_WIDTH  data seed; LFSR seed 0 is replaced by 1
- egress_srst  out  1  synchronous active-high reset for the downstream port
- egress_clk  out  1  equals gen_clk
- egress_write  out  1  flit valid, registered
- egress_data  out  FLIT_WIDTH  flit, registered
- egress_fifo_level  in  LOG2_FIFO_DEPTH+1  downstream ingress FIFO occupancy
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse when the run ends
- pkt_count  out  LEN_WIDTH  packets fully sent in the current run
- flit_count  out  32  flits written in the current run

## Operation
- All cfg_* inputs are sampled into shadow registers on an accepted start. They are don't-care afterwards.
- egress_srst: asserted asynchronously by gen_arst_n low. Deasserted through a 2-flop synchroniser, so it stays high for 2 gen_clk edges after gen_arst_n rises. The engine itself stays in IDLE while egress_srst is high.
- Credit: a write is permitted in a cycle only if egress_fifo_level < 2**LOG2_FIFO_DEPTH - FIFO_MARGIN. The level is compared as unsigned, (LOG2_FIFO_DEPTH+1)-bit.
- FSM states are IDLE, HEADER, PAYLOAD, GAP, END.
  - IDLE: on cfg_start, load the shadows and clear pkt_count and flit_count, then go to HEADER with hdr_idx=0.
  - HEADER: on credit, emit {1'b0, header[hdr_idx]}. After the last header word, go to PAYLOAD with pay_idx=0.
  - PAYLOAD: on credit, emit {last, data}, where last = (pay_idx==len-1) or stop is pending. After the last flit, increment pkt_count.
    - If stop is pending, or pkt_count reaches cfg_packets (when nonzero), go to END.
    - Otherwise go to GAP if gap≠0, else to HEADER.
  - GAP: count cfg_gap cycles with no write, then go to HEADER.
  - END: pulse done for one cycle, then go to IDLE.
- Data generation:
  - Incrementing: the first payload of the run is cfg_seed. Each payload adds +1 modulo 2**PAYLOAD_WIDTH, and the count continues across packets.
  - LFSR: Galois right-shift, state = (state>>1) ^ (state[0] ? LFSR_POLY : 0). The first emitted word is the seed, and the state advances only on emitted payload flits.
- cfg_stop is latched as stop_pending.
  - In HEADER: the remaining headers complete, then exactly one payload flit is sent with close=1.
  - In PAYLOAD: the next emitted flit carries close=1.
  - In GAP or IDLE: go to END (in IDLE, stop is ignored).
  - Packets are never left open.
- cfg_start while busy is ignored. cfg_start and cfg_stop together in IDLE means start wins and the stop is discarded.
- Reset mid-packet: all state returns to reset values immediately. The downstream sees egress_srst, which flushes the partial packet.

## Timing
- Reset values:
  - egress_write=0, egress_data=0, busy=0, done=0, pkt_count=0, flit_count=0, egress_srst=1.
  - FSM in IDLE.
- Latency: cfg_start sampled at edge k makes busy=1 after edge k. The first egress_write=1 follows edge k+1, given credit.
- egress_data is 0 whenever egress_write=0.
- Credit is evaluated from the level present in the cycle before the write edge. There is no combinational path from egress_fifo_level to the outputs.
- Maximum throughput is 1 flit per cycle.
- flit_count wraps modulo 2**32. pkt_count saturates at all-ones.

## Test plan
- Tie egress_fifo_level=0. Start with hdr=1, header0=0x0000_0AB2, len=1, packets=1, mode=0, seed=0xCAFEDECA. Required: flits 0x0_0000_0AB2 then 0x1_CAFEDECA on consecutive cycles, then done, and pkt_count=1.
- Start with hdr=3, len=3, packets=2, gap=4, seed=0x01234567. Required: 12 writes total, with payloads ...67, ...68, ...69 (close on ...69) and then ...6A, ...6B, ...6C. Exactly 4 idle cycles between the packets, flit_count=12.
- Hold egress_fifo_level=30, release it to 29 after 10 cycles, with depth 32 and margin 2. Required: no write while the level is 30, and writes resume once the level is 29.
- Set mode=1, seed=0, len=4. Required: payloads 0x00000001, 0x80200003, 0xC0300002, 0x60180001, with close on the 4th.
- Set packets=0 and len=100, then pulse stop on payload 5. Required: payload 6 carries close=1, then done, and pkt_count increments by 1.
- Pull gen_arst_n low mid-payload. Required: egress_write=0 and egress_srst=1 immediately; after release, egress_srst falls on the 2nd edge and a subsequent start works.
